// File: rtl/reflet_dma_if.sv
// Signal bundle for the DMA: config responder port, initiator bus port and interrupt.
// The master modport is the DMA side; slave is the system side facing it.
interface reflet_dma_if #(
  parameter int wordsize       = 16,
  parameter int base_addr_size = 16
);
  logic                      enable;
  logic [base_addr_size-1:0] addr;
  logic [wordsize-1:0]       data_in;
  logic [wordsize-1:0]       data_out;
  logic                      write_en;
  logic                      interrupt;
  logic                      bus_req;
  logic                      bus_gnt;
  logic [base_addr_size-1:0] bus_addr;
  logic [wordsize-1:0]       bus_dout;
  logic [wordsize-1:0]       bus_din;
  logic                      bus_we;

  modport master (
    input  enable, addr, data_in, write_en, bus_gnt, bus_din,
    output data_out, interrupt, bus_req, bus_addr, bus_dout, bus_we
  );

  modport slave (
    output enable, addr, data_in, write_en, bus_gnt, bus_din,
    input  data_out, interrupt, bus_req, bus_addr, bus_dout, bus_we
  );
endinterface

// File: rtl/reflet_dma.sv
// DMA engine: copies COUNT words from SRC to DST as a second bus initiator,
// holding the bus for the whole transfer; done & int_en drives the interrupt.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | bus_req raised, waiting for grant
// RADDR | source address on the bus
// RDATA | source address held, read data captured
// WRITE | buffered word written to destination, pointers advance
// DONE  | one-cycle completion, done flag set
module reflet_dma #(
  parameter int                        wordsize       = 16,
  parameter int                        base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr      = 16'hFF20
) (
  input  logic         clk,
  input  logic         reset,
  reflet_dma_if.master port
);

  typedef enum logic [2:0] {IDLE, REQ, RADDR, RDATA, WRITE, DONE} state_t;

  localparam logic [base_addr_size-1:0] one_addr = {{(base_addr_size-1){1'b0}}, 1'b1};
  localparam logic [wordsize-1:0]       one_word = {{(wordsize-1){1'b0}}, 1'b1};

  state_t                    state, state_nx;
  logic [base_addr_size-1:0] src, dst, offset;
  logic [wordsize-1:0]       count, buffer, rdata;
  logic                      src_inc, dst_inc, int_en, done;
  logic                      sel, wr, busy, cfg_ok, start, clr_done, step;

  assign offset   = port.addr - base_addr;
  assign sel      = port.enable && (offset[base_addr_size-1:2] == '0);
  assign wr       = sel && port.write_en;
  assign busy     = (state == REQ) || (state == RADDR) || (state == RDATA) || (state == WRITE);
  assign cfg_ok   = wr && !busy;
  assign start    = cfg_ok && (offset[1:0] == 2'd0) && port.data_in[0] && (state == IDLE);
  // Done-clear is honoured even while busy; everything else is locked out.
  assign clr_done = wr && (offset[1:0] == 2'd0) && port.data_in[4];
  assign step     = (state == WRITE) && port.bus_gnt;

  always_comb begin
    state_nx      = state;
    port.bus_req  = 1'b0;
    port.bus_addr = '0;
    port.bus_dout = '0;
    port.bus_we   = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nx = (count == '0) ? DONE : REQ;
      REQ: begin
        port.bus_req = 1'b1;
        if (port.bus_gnt) state_nx = RADDR;
      end
      RADDR, RDATA: begin
        port.bus_req = 1'b1;
        if (port.bus_gnt) begin
          port.bus_addr = src;
          state_nx      = (state == RADDR) ? RDATA : WRITE;
        end
      end
      WRITE: begin
        port.bus_req = 1'b1;
        if (port.bus_gnt) begin
          port.bus_addr = dst;
          port.bus_dout = buffer;
          port.bus_we   = 1'b1;
          state_nx      = (count == one_word) ? DONE : RADDR;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      src     <= '0;
      dst     <= '0;
      count   <= '0;
      buffer  <= '0;
      src_inc <= 1'b0;
      dst_inc <= 1'b0;
      int_en  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_nx;
      if (cfg_ok) begin
        unique case (offset[1:0])
          2'd0: {int_en, dst_inc, src_inc} <= port.data_in[3:1];
          2'd1: src   <= port.data_in;
          2'd2: dst   <= port.data_in;
          2'd3: count <= port.data_in;
          default: ;
        endcase
      end
      if ((state == RDATA) && port.bus_gnt) buffer <= port.bus_din;
      if (step) begin
        count <= count - one_word;
        if (src_inc) src <= src + one_addr;
        if (dst_inc) dst <= dst + one_addr;
      end
      if (state_nx == DONE)  done <= 1'b1;
      else if (clr_done)     done <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (offset[1:0])
        2'd0: rdata = {{(wordsize-5){1'b0}}, done, int_en, dst_inc, src_inc, busy};
        2'd1: rdata = src;
        2'd2: rdata = dst;
        2'd3: rdata = count;
        default: rdata = '0;
      endcase
    end
  end

  assign port.data_out  = rdata;
  assign port.interrupt = done & int_en;

endmodule

// File: tb/tb_reflet_dma.sv
// Directed bench for reflet_dma: small memory model on the initiator port,
// hand-computed expectations for copies, stalls, busy lockout and reset.
module tb_reflet_dma;
  localparam logic [15:0] B    = 16'hFF20;
  localparam logic [15:0] CTRL = B;
  localparam logic [15:0] SRC  = B + 16'd1;
  localparam logic [15:0] DST  = B + 16'd2;
  localparam logic [15:0] CNT  = B + 16'd3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reflet_dma_if #(.wordsize(16), .base_addr_size(16)) dif ();

  reflet_dma #(.wordsize(16), .base_addr_size(16), .base_addr(16'hFF20)) dut (
    .clk  (clk),
    .reset(reset),
    .port (dif)
  );

  logic [15:0] mem [0:65535];
  logic        ld;
  logic [15:0] ld_a, ld_d;
  logic [15:0] wa[$];
  logic [15:0] wd[$];
  int          wc[$];
  int          cyc = 0;
  int          req_cnt = 0;

  // Memory responder: read data one cycle after the address, writes logged.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dif.bus_req) req_cnt <= req_cnt + 1;
    if (ld) mem[ld_a] <= ld_d;
    else if (dif.bus_we) begin
      mem[dif.bus_addr] <= dif.bus_dout;
      wa.push_back(dif.bus_addr);
      wd.push_back(dif.bus_dout);
      wc.push_back(cyc);
    end
    dif.bus_din <= mem[dif.bus_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    ld = 1'b1; ld_a = a; ld_d = d;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic cfg_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    dif.enable = 1'b1; dif.write_en = 1'b1; dif.addr = a; dif.data_in = d;
    @(negedge clk);
    dif.enable = 1'b0; dif.write_en = 1'b0;
  endtask

  task automatic cfg_read(input logic [15:0] a, output logic [15:0] v);
    dif.enable = 1'b1; dif.write_en = 1'b0; dif.addr = a;
    #1;
    v = dif.data_out;
  endtask

  task automatic wait_done(output int cycles);
    logic [15:0] v;
    cycles = 0;
    cfg_read(CTRL, v);
    while (!v[4] && cycles < 200) begin
      @(negedge clk);
      cycles++;
      cfg_read(CTRL, v);
    end
    if (cycles >= 200) chk("done_timeout", 32'(cycles), 32'd0);
  endtask

  task automatic start_xfer(input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] n, input logic [15:0] c);
    cfg_write(SRC, s);
    cfg_write(DST, d);
    cfg_write(CNT, n);
    cfg_write(CTRL, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    int          w, n0, r0;
    logic [15:0] exp_a[5];
    logic [15:0] exp_d[5];

    reset = 1'b1; ld = 1'b0; ld_a = '0; ld_d = '0;
    dif.enable = 1'b0; dif.write_en = 1'b0; dif.addr = '0; dif.data_in = '0;
    dif.bus_gnt = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_bus_req", 32'(dif.bus_req), 32'd0);
    chk("rst_bus_we", 32'(dif.bus_we), 32'd0);
    chk("rst_bus_addr", 32'(dif.bus_addr), 32'd0);
    chk("rst_bus_dout", 32'(dif.bus_dout), 32'd0);
    chk("rst_interrupt", 32'(dif.interrupt), 32'd0);
    chk("rst_data_out", 32'(dif.data_out), 32'd0);
    reset = 1'b0;
    cfg_read(CTRL, v);  chk("rst_ctrl", 32'(v), 32'h0);
    cfg_read(B + 16'd4, v); chk("unaddressed_read", 32'(v), 32'h0);

    poke(16'h0100, 16'h1111); poke(16'h0101, 16'h2222); poke(16'h0102, 16'h3333);
    poke(16'h0103, 16'h4444); poke(16'h0104, 16'h5555);
    poke(16'hFFFF, 16'hAAAA); poke(16'h0000, 16'hBBBB);

    // Basic copy with increments and interrupt.
    n0 = wa.size();
    start_xfer(16'h0100, 16'h0200, 16'd3, 16'h000F);
    wait_done(w);
    chk("basic_cycles", 32'(w), 32'd10);
    chk("basic_nwrites", 32'(wa.size() - n0), 32'd3);
    exp_a[0] = 16'h0200; exp_a[1] = 16'h0201; exp_a[2] = 16'h0202;
    exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      chk("basic_waddr", 32'(wa[n0+i]), 32'(exp_a[i]));
      chk("basic_wdata", 32'(wd[n0+i]), 32'(exp_d[i]));
    end
    chk("basic_spacing", 32'(wc[n0+2] - wc[n0+1]), 32'd3);
    cfg_read(CTRL, v); chk("basic_ctrl", 32'(v), 32'h001E);
    chk("basic_irq", 32'(dif.interrupt), 32'd1);
    cfg_read(SRC, v);  chk("basic_src", 32'(v), 32'h0103);
    cfg_read(DST, v);  chk("basic_dst", 32'(v), 32'h0203);
    cfg_read(CNT, v);  chk("basic_cnt", 32'(v), 32'h0000);

    // Fixed destination, source increments only.
    n0 = wa.size();
    start_xfer(16'h0100, 16'hFF08, 16'd2, 16'h0013);
    wait_done(w);
    chk("fixed_cycles", 32'(w), 32'd7);
    chk("fixed_nwrites", 32'(wa.size() - n0), 32'd2);
    chk("fixed_waddr0", 32'(wa[n0]), 32'hFF08);
    chk("fixed_waddr1", 32'(wa[n0+1]), 32'hFF08);
    chk("fixed_wdata1", 32'(wd[n0+1]), 32'h2222);
    cfg_read(SRC, v);  chk("fixed_src", 32'(v), 32'h0102);
    cfg_read(DST, v);  chk("fixed_dst", 32'(v), 32'hFF08);
    chk("fixed_irq_masked", 32'(dif.interrupt), 32'd0);

    // Zero count with simultaneous done-clear: done set wins, no bus request.
    cfg_write(CNT, 16'd0);
    r0 = req_cnt;
    cfg_write(CTRL, 16'h0011);
    wait_done(w);
    chk("zero_cycles", 32'(w), 32'd0);
    repeat (2) @(negedge clk);
    chk("zero_no_req", 32'(req_cnt - r0), 32'd0);
    cfg_read(CTRL, v); chk("zero_ctrl", 32'(v), 32'h0010);

    // Source pointer wrap.
    n0 = wa.size();
    start_xfer(16'hFFFF, 16'h0400, 16'd2, 16'h0017);
    wait_done(w);
    chk("wrap_cycles", 32'(w), 32'd7);
    chk("wrap_wdata0", 32'(wd[n0]), 32'hAAAA);
    chk("wrap_wdata1", 32'(wd[n0+1]), 32'hBBBB);
    chk("wrap_waddr1", 32'(wa[n0+1]), 32'h0401);
    cfg_read(SRC, v);  chk("wrap_src", 32'(v), 32'h0001);

    // Grant dropped for 5 cycles during the second write.
    n0 = wa.size();
    start_xfer(16'h0100, 16'h0300, 16'd3, 16'h0017);
    repeat (6) @(negedge clk);
    #1;
    chk("stall_pre_we", 32'(dif.bus_we), 32'd1);
    chk("stall_pre_addr", 32'(dif.bus_addr), 32'h0301);
    dif.bus_gnt = 1'b0;
    #1;
    chk("stall_we", 32'(dif.bus_we), 32'd0);
    chk("stall_addr", 32'(dif.bus_addr), 32'h0000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("stall_hold_we", 32'(dif.bus_we), 32'd0);
    end
    @(negedge clk);
    dif.bus_gnt = 1'b1;
    wait_done(w);
    chk("stall_cycles", 32'(11 + w), 32'd15);
    chk("stall_nwrites", 32'(wa.size() - n0), 32'd3);
    chk("stall_gap", 32'(wc[n0+1] - wc[n0]), 32'd8);
    exp_a[0] = 16'h0300; exp_a[1] = 16'h0301; exp_a[2] = 16'h0302;
    for (int i = 0; i < 3; i++) begin
      chk("stall_waddr", 32'(wa[n0+i]), 32'(exp_a[i]));
      chk("stall_wdata", 32'(wd[n0+i]), 32'(exp_d[i]));
    end

    // Busy lockout, live COUNT readback, then done clear.
    n0 = wa.size();
    start_xfer(16'h0100, 16'h0500, 16'd5, 16'h001F);
    repeat (3) @(negedge clk);
    cfg_write(CNT, 16'd7);
    cfg_read(CNT, v);  chk("busy_cnt_a", 32'(v), 32'd4);
    cfg_write(CTRL, 16'h0001);
    cfg_read(CNT, v);  chk("busy_cnt_b", 32'(v), 32'd3);
    cfg_read(CTRL, v); chk("busy_ctrl", 32'(v), 32'h000F);
    wait_done(w);
    chk("busy_cycles", 32'(w), 32'd9);
    chk("busy_nwrites", 32'(wa.size() - n0), 32'd5);
    exp_d[3] = 16'h4444; exp_d[4] = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      chk("busy_waddr", 32'(wa[n0+i]), 32'(16'h0500 + 16'(i)));
      chk("busy_wdata", 32'(wd[n0+i]), 32'(exp_d[i]));
    end
    chk("busy_irq", 32'(dif.interrupt), 32'd1);
    cfg_write(CTRL, 16'h0018);
    #1;
    chk("clear_irq", 32'(dif.interrupt), 32'd0);
    cfg_read(CTRL, v); chk("clear_ctrl", 32'(v), 32'h0008);

    // Reset during RDATA of the first word.
    n0 = wa.size();
    start_xfer(16'h0100, 16'h0600, 16'd3, 16'h000F);
    repeat (2) @(negedge clk);
    #1;
    chk("mid_rdata_addr", 32'(dif.bus_addr), 32'h0100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_bus_req", 32'(dif.bus_req), 32'd0);
    chk("mid_bus_we", 32'(dif.bus_we), 32'd0);
    chk("mid_bus_addr", 32'(dif.bus_addr), 32'd0);
    chk("mid_irq", 32'(dif.interrupt), 32'd0);
    cfg_read(CTRL, v); chk("mid_ctrl", 32'(v), 32'h0);
    cfg_read(SRC, v);  chk("mid_src", 32'(v), 32'h0);
    cfg_read(DST, v);  chk("mid_dst", 32'(v), 32'h0);
    cfg_read(CNT, v);  chk("mid_cnt", 32'(v), 32'h0);
    repeat (6) @(negedge clk);
    chk("mid_no_write", 32'(wa.size() - n0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
